// File: rtl/phy_pkg.sv
// Shared PHY TX constants: K-symbols, default lane geometry and index sizing.
// Used by byte_striping_nlane (optional feature macro: LANE_REVERSAL_EN).
package phy_pkg;

  localparam logic [7:0] PAD_SYM = 8'hF7;
  localparam logic [7:0] COM_SYM = 8'hBC;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_LANES = 2;
  localparam int MAX_LANES     = 16;

  // A lane index always needs at least one bit, even for a single lane.
  function automatic int idx_width(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/stripe_frame_buf.sv
// Output frame register for the lane striper: valid/ready hold logic and the
// frames-sent counter.
module stripe_frame_buf #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                        clk_2f,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NUM_LANES*DATA_W-1:0] load_data,
  input  logic [NUM_LANES-1:0]        load_mask,
  output logic                        can_load,
  output logic [NUM_LANES*DATA_W-1:0] lanes_out,
  output logic [NUM_LANES-1:0]        lane_valid,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [CNT_W-1:0]            frame_cnt
);

  logic consume;

  assign consume  = frame_valid && frame_ready;
  assign can_load = !frame_valid || frame_ready;

  // A new frame may replace the held one in the same edge it is consumed.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      lanes_out   <= '0;
      lane_valid  <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (consume) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (load) begin
        lanes_out   <= load_data;
        lane_valid  <= load_mask;
        frame_valid <= 1'b1;
      end else if (consume) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/byte_striping_nlane.sv
// Round-robin byte striper feeding NUM_LANES serializer lanes as whole frames.
// Optional macro LANE_REVERSAL_EN adds lane_rev to mirror the lane order.
module byte_striping_nlane
  import phy_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 NUM_LANES = DEF_NUM_LANES,
  parameter logic [DATA_W-1:0]  PAD_BYTE  = DATA_W'(PAD_SYM),
  parameter int                 CNT_W     = 16
) (
  input  logic                        clk_2f,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  output logic                        in_ready,
  input  logic                        flush,
`ifdef LANE_REVERSAL_EN
  input  logic                        lane_rev,
`endif
  output logic [NUM_LANES*DATA_W-1:0] lanes_out,
  output logic [NUM_LANES-1:0]        lane_valid,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [CNT_W-1:0]            frame_cnt
);

  localparam int                IDX_W    = idx_width(NUM_LANES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LANES - 1);

  if (NUM_LANES < 1 || NUM_LANES > MAX_LANES) begin : g_bad_lanes
    $error("byte_striping_nlane: NUM_LANES must be 1..16");
  end

  logic [IDX_W-1:0]                  idx;
  logic                              coll_full;
  logic [NUM_LANES-1:0][DATA_W-1:0]  coll_data;
  logic [NUM_LANES-1:0]              coll_mask;

  logic [NUM_LANES-1:0][DATA_W-1:0]  next_data;
  logic [NUM_LANES-1:0]              next_mask;
  logic [NUM_LANES-1:0][DATA_W-1:0]  src_data;
  logic [NUM_LANES-1:0]              src_mask;
  logic [NUM_LANES-1:0][DATA_W-1:0]  load_data;
  logic [NUM_LANES-1:0]              load_mask;

  logic accept;
  logic flush_close;
  logic close_now;
  logic can_load;
  logic load;

  assign in_ready    = reset && !coll_full;
  assign accept      = valid_in && in_ready;
  assign flush_close = flush && !coll_full && ((idx != '0) || accept);
  assign close_now   = (accept && (idx == LAST_IDX)) || flush_close;
  assign load        = can_load && (coll_full || close_now);

  // Collection contents as they would look after this cycle's byte lands.
  always_comb begin
    next_data = coll_data;
    next_mask = coll_mask;
    if (accept) begin
      next_data[idx] = data_in;
      next_mask[idx] = 1'b1;
    end
  end

  always_comb begin
    src_data = coll_full ? coll_data : next_data;
    src_mask = coll_full ? coll_mask : next_mask;
  end

  always_comb begin
    load_data = src_data;
    load_mask = src_mask;
`ifdef LANE_REVERSAL_EN
    if (lane_rev) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        load_data[k] = src_data[NUM_LANES-1-k];
        load_mask[k] = src_mask[NUM_LANES-1-k];
      end
    end
`endif
  end

  // Cleared slots hold PAD so a flushed frame needs no extra fill step.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      idx       <= '0;
      coll_full <= 1'b0;
      coll_data <= {NUM_LANES{PAD_BYTE}};
      coll_mask <= '0;
    end else if (coll_full) begin
      if (can_load) begin
        idx       <= '0;
        coll_full <= 1'b0;
        coll_data <= {NUM_LANES{PAD_BYTE}};
        coll_mask <= '0;
      end
    end else if (close_now) begin
      idx <= '0;
      if (can_load) begin
        coll_data <= {NUM_LANES{PAD_BYTE}};
        coll_mask <= '0;
      end else begin
        coll_data <= next_data;
        coll_mask <= next_mask;
        coll_full <= 1'b1;
      end
    end else if (accept) begin
      coll_data <= next_data;
      coll_mask <= next_mask;
      idx       <= idx + IDX_W'(1);
    end
  end

  stripe_frame_buf #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W)
  ) u_frame_buf (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .load        (load),
    .load_data   (load_data),
    .load_mask   (load_mask),
    .can_load    (can_load),
    .lanes_out   (lanes_out),
    .lane_valid  (lane_valid),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cnt   (frame_cnt)
  );

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Directed bench for byte_striping_nlane with four 8-bit lanes.
// Build with LANE_REVERSAL_EN defined to also cover the lane_rev path.
module tb_byte_striping_nlane;

  localparam int DATA_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 16;

  logic                        clk_2f;
  logic                        reset;
  logic [DATA_W-1:0]           data_in;
  logic                        valid_in;
  logic                        in_ready;
  logic                        flush;
`ifdef LANE_REVERSAL_EN
  logic                        lane_rev;
`endif
  logic [NUM_LANES*DATA_W-1:0] lanes_out;
  logic [NUM_LANES-1:0]        lane_valid;
  logic                        frame_valid;
  logic                        frame_ready;
  logic [CNT_W-1:0]            frame_cnt;

  int checks = 0;
  int errors = 0;

  byte_striping_nlane #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .PAD_BYTE  (8'hF7),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .flush       (flush),
`ifdef LANE_REVERSAL_EN
    .lane_rev    (lane_rev),
`endif
    .lanes_out   (lanes_out),
    .lane_valid  (lane_valid),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cnt   (frame_cnt)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Inputs change 1 time unit after a rising edge, outputs are read there too.
  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset       = 1'b0;
    valid_in    = 1'b1;
    data_in     = 8'h55;
    flush       = 1'b0;
    frame_ready = 1'b1;
`ifdef LANE_REVERSAL_EN
    lane_rev    = 1'b0;
`endif

    $display("[TB] reset");
    step(); step(); step();
    checkOutput("rst_lanes",  64'(lanes_out),   64'h0);
    checkOutput("rst_lvalid", 64'(lane_valid),  64'h0);
    checkOutput("rst_fvalid", 64'(frame_valid), 64'h0);
    checkOutput("rst_ready",  64'(in_ready),    64'h0);
    checkOutput("rst_cnt",    64'(frame_cnt),   64'h0);
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    checkOutput("rel_ready", 64'(in_ready), 64'h1);

    $display("[TB] streaming");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("str_ready", 64'(in_ready), 64'h1);
      if (i == 4) begin
        checkOutput("str_f1_lanes", 64'(lanes_out),   64'h04030201);
        checkOutput("str_f1_mask",  64'(lane_valid),  64'hF);
        checkOutput("str_f1_valid", 64'(frame_valid), 64'h1);
      end
      if (i == 8) begin
        checkOutput("str_f2_lanes", 64'(lanes_out),  64'h08070605);
        checkOutput("str_f2_mask",  64'(lane_valid), 64'hF);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("str_cnt",    64'(frame_cnt),   64'd2);
    checkOutput("str_fvdrop", 64'(frame_valid), 64'h0);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    checkOutput("fl_noframe", 64'(frame_valid), 64'h0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("fl_lanes", 64'(lanes_out),   64'hF7F7BBAA);
    checkOutput("fl_mask",  64'(lane_valid),  64'h3);
    checkOutput("fl_valid", 64'(frame_valid), 64'h1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("fl_idx0_none", 64'(frame_valid), 64'h0);
    checkOutput("fl_idx0_cnt",  64'(frame_cnt),   64'd3);
    applyStimulus(1'b1, 8'hCC, 1'b1);
    checkOutput("fl_same_lanes", 64'(lanes_out),  64'hF7F7F7CC);
    checkOutput("fl_same_mask",  64'(lane_valid), 64'h1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fl_same_cnt", 64'(frame_cnt), 64'd4);

    $display("[TB] backpressure");
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      if (i >= 3) begin
        checkOutput("bp_hold_lanes", 64'(lanes_out),   64'h13121110);
        checkOutput("bp_hold_valid", 64'(frame_valid), 64'h1);
      end
    end
    checkOutput("bp_ready_low", 64'(in_ready), 64'h0);
    applyStimulus(1'b1, 8'h18, 1'b1);
    applyStimulus(1'b1, 8'h18, 1'b0);
    checkOutput("bp_still_low",  64'(in_ready),  64'h0);
    checkOutput("bp_still_held", 64'(lanes_out), 64'h13121110);
    checkOutput("bp_cnt_held",   64'(frame_cnt), 64'd4);
    valid_in    = 1'b0;
    frame_ready = 1'b1;
    step();
    checkOutput("bp_f2_lanes", 64'(lanes_out),  64'h17161514);
    checkOutput("bp_f2_mask",  64'(lane_valid), 64'hF);
    checkOutput("bp_cnt5",     64'(frame_cnt),  64'd5);
    checkOutput("bp_ready_up", 64'(in_ready),   64'h1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bp_cnt6",  64'(frame_cnt),   64'd6);
    checkOutput("bp_drain", 64'(frame_valid), 64'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0);
    valid_in = 1'b0;
    reset    = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("mr_no_frame", 64'(frame_valid), 64'h0);
    checkOutput("mr_cnt",      64'(frame_cnt),   64'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      if (i < 3) checkOutput("mr_early", 64'(frame_valid), 64'h0);
    end
    checkOutput("mr_lanes", 64'(lanes_out),  64'h43424140);
    checkOutput("mr_mask",  64'(lane_valid), 64'hF);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mr_cnt1", 64'(frame_cnt), 64'd1);

`ifdef LANE_REVERSAL_EN
    $display("[TB] lane reversal");
    lane_rev = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("rev_lanes", 64'(lanes_out), 64'h11223344);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rev_lanes_fl", 64'(lanes_out),  64'hAAF7F7F7);
    checkOutput("rev_mask_fl",  64'(lane_valid), 64'h8);
    lane_rev = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
